// File: rtl/irq_latch_ctrl.sv
// ============================================================================
// irq_latch_ctrl
// ----------------------------------------------------------------------------
// Interrupt-request latch controller for the CPU interrupt inputs.
//
// Rising edges on the request sources are latched into Pending. A per-source
// Mask gates which latched requests reach the CPU lines. Source 0 is the NMI
// source: when it is pending and enabled, a sequencer produces a fixed-width
// active-low NMI pulse and then auto-clears the latch. Sources 1..SOURCES-1
// are routed to FIRQ or IRQ by FIRQ_MAP. A lowest-index priority encoder
// reports which of those sources to service first.
//
// Parameters:
//   SOURCES    number of request sources (>= 2), source 0 is NMI
//   FIRQ_MAP   bit i set routes source i (i >= 1) to FIRQ_bar, else IRQ_bar
//   NMI_PULSE  NMI_bar low width in Clk cycles (>= 1)
//   MASK_INIT  Mask value loaded at reset
//
// Ports:
//   Clk        in   system clock, all state changes on the rising edge
//   Reset      in   synchronous active-high reset
//   Src        in   request levels, rising edge = request
//   Ack        in   per-source one-cycle clear strobes
//   Mask_we    in   load Mask from Mask_din
//   Mask_din   in   new mask value (1 = enabled)
//   Mask       out  current mask
//   Pending    out  latched requests
//   NMI_bar    out  active-low NMI pulse
//   FIRQ_bar   out  active-low FIRQ
//   IRQ_bar    out  active-low IRQ
//   Vector_id  out  lowest-index enabled pending source among 1..SOURCES-1,
//                   0 when none
//   Any_irq    out  some enabled source 1..SOURCES-1 is pending
// ============================================================================
`timescale 1ns/1ps

module irq_latch_ctrl #(
    parameter int                 SOURCES   = 4,
    parameter logic [SOURCES-1:0] FIRQ_MAP  = SOURCES'(4'b0010),
    parameter int                 NMI_PULSE = 8,
    parameter logic [SOURCES-1:0] MASK_INIT = {SOURCES{1'b1}}
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [SOURCES-1:0]         Src,
    input  logic [SOURCES-1:0]         Ack,
    input  logic                       Mask_we,
    input  logic [SOURCES-1:0]         Mask_din,
    output logic [SOURCES-1:0]         Mask,
    output logic [SOURCES-1:0]         Pending,
    output logic                       NMI_bar,
    output logic                       FIRQ_bar,
    output logic                       IRQ_bar,
    output logic [$clog2(SOURCES)-1:0] Vector_id,
    output logic                       Any_irq
);

    localparam int VW = $clog2(SOURCES);

    // A 1-cycle pulse still needs a 1-bit counter to hold the value 0.
    localparam int CW = (NMI_PULSE > 1) ? $clog2(NMI_PULSE) : 1;
    localparam logic [CW-1:0] PULSE_LOAD = CW'(NMI_PULSE - 1);

    // Every source except the NMI source.
    localparam logic [SOURCES-1:0] NON_NMI = {{(SOURCES-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } nmi_state_t;

    logic [SOURCES-1:0] src_d;
    logic [SOURCES-1:0] src_rise;
    logic [SOURCES-1:0] clear_vec;
    logic [SOURCES-1:0] pending_next;
    logic [SOURCES-1:0] enabled;
    logic [SOURCES-1:0] firq_set;
    logic [SOURCES-1:0] irq_set;
    logic [VW-1:0]      vector_next;
    logic               nmi_request;
    logic               nmi_autoclr;

    nmi_state_t         nmi_state;
    logic [CW-1:0]      nmi_count;

    // Edge detection against the previous Src sample. src_d resets to all
    // ones so a source that is already high when reset releases is not seen
    // as a new request.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            src_d <= '1;
        end else begin
            src_d <= Src;
        end
    end

    assign src_rise = Src & ~src_d;

    // The NMI latch is released automatically on the last cycle of the pulse.
    assign nmi_autoclr = (nmi_state == ST_PULSE) && (nmi_count == '0);

    // Clear sources are Ack for every bit plus the NMI auto-clear on bit 0.
    // A rising edge in the same cycle always wins over any clear, so a
    // request arriving as the CPU acknowledges the previous one is not lost.
    always_comb begin
        clear_vec    = Ack;
        clear_vec[0] = Ack[0] | nmi_autoclr;
        pending_next = src_rise | (Pending & ~clear_vec);
    end

    // Request latches. These latch regardless of Mask so that unmasking a
    // source with an outstanding request raises its line.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Pending <= '0;
        end else begin
            Pending <= pending_next;
        end
    end

    // Mask register, written independently of edges and acknowledges.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Mask <= MASK_INIT;
        end else if (Mask_we) begin
            Mask <= Mask_din;
        end
    end

    // Enabled maskable requests split by destination line. The NMI source
    // never contributes to FIRQ, IRQ or the vector.
    assign enabled  = Pending & Mask & NON_NMI;
    assign firq_set = enabled & FIRQ_MAP;
    assign irq_set  = enabled & ~FIRQ_MAP;

    // Lowest-index priority encoder. Scanning from the top down lets the
    // lowest enabled index overwrite any higher one.
    always_comb begin
        vector_next = '0;
        for (int i = SOURCES - 1; i >= 1; i--) begin
            if (enabled[i]) begin
                vector_next = VW'(i);
            end
        end
    end

    // Registered CPU-facing outputs for the maskable lines, so they follow
    // Pending and Mask by one cycle and never glitch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FIRQ_bar  <= 1'b1;
            IRQ_bar   <= 1'b1;
            Vector_id <= '0;
            Any_irq   <= 1'b0;
        end else begin
            FIRQ_bar  <= ~|firq_set;
            IRQ_bar   <= ~|irq_set;
            Vector_id <= vector_next;
            Any_irq   <= |enabled;
        end
    end

    assign nmi_request = Pending[0] & Mask[0];

    // NMI pulse sequencer. Once a pulse starts it always runs its full
    // width; masking or acknowledging source 0 mid-pulse only affects the
    // latch. GAP guarantees at least one high cycle between pulses, and a
    // request still pending there starts the next pulse straight away so
    // the gap is exactly one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            nmi_state <= ST_IDLE;
            nmi_count <= '0;
            NMI_bar   <= 1'b1;
        end else begin
            case (nmi_state)
                ST_IDLE: begin
                    if (nmi_request) begin
                        nmi_state <= ST_PULSE;
                        nmi_count <= PULSE_LOAD;
                        NMI_bar   <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (nmi_count == '0) begin
                        nmi_state <= ST_GAP;
                        NMI_bar   <= 1'b1;
                    end else begin
                        nmi_count <= nmi_count - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (nmi_request) begin
                        nmi_state <= ST_PULSE;
                        nmi_count <= PULSE_LOAD;
                        NMI_bar   <= 1'b0;
                    end else begin
                        nmi_state <= ST_IDLE;
                    end
                end
                default: begin
                    nmi_state <= ST_IDLE;
                    NMI_bar   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_latch_ctrl.sv
// ============================================================================
// tb_irq_latch_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for irq_latch_ctrl with default parameters
// (SOURCES=4, FIRQ_MAP=4'b0010, NMI_PULSE=8, MASK_INIT=4'b1111).
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// so each tick() shows the state produced by exactly one clock edge.
// ============================================================================
`timescale 1ns/1ps

module tb_irq_latch_ctrl;

    logic       Clk;
    logic       Reset;
    logic [3:0] Src;
    logic [3:0] Ack;
    logic       Mask_we;
    logic [3:0] Mask_din;
    logic [3:0] Mask;
    logic [3:0] Pending;
    logic       NMI_bar;
    logic       FIRQ_bar;
    logic       IRQ_bar;
    logic [1:0] Vector_id;
    logic       Any_irq;

    int checks;
    int failures;

    irq_latch_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Src       (Src),
        .Ack       (Ack),
        .Mask_we   (Mask_we),
        .Mask_din  (Mask_din),
        .Mask      (Mask),
        .Pending   (Pending),
        .NMI_bar   (NMI_bar),
        .FIRQ_bar  (FIRQ_bar),
        .IRQ_bar   (IRQ_bar),
        .Vector_id (Vector_id),
        .Any_irq   (Any_irq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance across one rising edge and settle just after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Held reset with sources 1 and 2 high, then release.
    task automatic test_reset();
        Reset = 1'b1; Src = 4'b0110; Ack = 4'b0000;
        Mask_we = 1'b0; Mask_din = 4'b0000;
        tick(); tick();
        checks++; if (Pending !== 4'b0000) begin failures++; $display("[TB] FAIL reset_pending got=%b exp=%b", Pending, 4'b0000); end
        checks++; if (Mask !== 4'b1111) begin failures++; $display("[TB] FAIL reset_mask got=%b exp=%b", Mask, 4'b1111); end
        checks++; if ({NMI_bar, FIRQ_bar, IRQ_bar} !== 3'b111) begin failures++; $display("[TB] FAIL reset_lines got=%b exp=%b", {NMI_bar, FIRQ_bar, IRQ_bar}, 3'b111); end
        checks++; if ({Vector_id, Any_irq} !== 3'b000) begin failures++; $display("[TB] FAIL reset_vec got=%b exp=%b", {Vector_id, Any_irq}, 3'b000); end
        Reset = 1'b0;
        tick(); tick(); tick();
        checks++; if (Pending !== 4'b0000) begin failures++; $display("[TB] FAIL release_pending got=%b exp=%b", Pending, 4'b0000); end
        checks++; if ({NMI_bar, FIRQ_bar, IRQ_bar} !== 3'b111) begin failures++; $display("[TB] FAIL release_lines got=%b exp=%b", {NMI_bar, FIRQ_bar, IRQ_bar}, 3'b111); end
    endtask

    // Drop and re-raise Src[1]: FIRQ asserts two edges after the rise.
    task automatic test_firq_edge();
        Src = 4'b0100; tick();
        Src = 4'b0110; tick();
        checks++; if (Pending !== 4'b0010) begin failures++; $display("[TB] FAIL firq_pending got=%b exp=%b", Pending, 4'b0010); end
        checks++; if (FIRQ_bar !== 1'b1) begin failures++; $display("[TB] FAIL firq_early got=%b exp=%b", FIRQ_bar, 1'b1); end
        tick();
        checks++; if ({FIRQ_bar, IRQ_bar} !== 2'b01) begin failures++; $display("[TB] FAIL firq_lines got=%b exp=%b", {FIRQ_bar, IRQ_bar}, 2'b01); end
        checks++; if ({Vector_id, Any_irq} !== 3'b011) begin failures++; $display("[TB] FAIL firq_vec got=%b exp=%b", {Vector_id, Any_irq}, 3'b011); end
        Ack = 4'b0010; tick(); Ack = 4'b0000;
        checks++; if (Pending !== 4'b0000) begin failures++; $display("[TB] FAIL firq_ack_pending got=%b exp=%b", Pending, 4'b0000); end
        checks++; if (FIRQ_bar !== 1'b0) begin failures++; $display("[TB] FAIL firq_ack_lag got=%b exp=%b", FIRQ_bar, 1'b0); end
        tick();
        checks++; if (FIRQ_bar !== 1'b1) begin failures++; $display("[TB] FAIL firq_ack_line got=%b exp=%b", FIRQ_bar, 1'b1); end
    endtask

    // Sources 2 and 3 together on IRQ; priority and per-source acknowledge.
    task automatic test_priority();
        Src = 4'b0010; tick();
        Src = 4'b1110; tick();
        checks++; if (Pending !== 4'b1100) begin failures++; $display("[TB] FAIL prio_pending got=%b exp=%b", Pending, 4'b1100); end
        tick();
        checks++; if ({FIRQ_bar, IRQ_bar} !== 2'b10) begin failures++; $display("[TB] FAIL prio_lines got=%b exp=%b", {FIRQ_bar, IRQ_bar}, 2'b10); end
        checks++; if (Vector_id !== 2'd2) begin failures++; $display("[TB] FAIL prio_vec2 got=%0d exp=%0d", Vector_id, 2); end
        Ack = 4'b0100; tick(); Ack = 4'b0000;
        checks++; if (Pending !== 4'b1000) begin failures++; $display("[TB] FAIL prio_ack2_pending got=%b exp=%b", Pending, 4'b1000); end
        tick();
        checks++; if (Vector_id !== 2'd3) begin failures++; $display("[TB] FAIL prio_vec3 got=%0d exp=%0d", Vector_id, 3); end
        checks++; if (IRQ_bar !== 1'b0) begin failures++; $display("[TB] FAIL prio_irq_held got=%b exp=%b", IRQ_bar, 1'b0); end
        Ack = 4'b1000; tick(); Ack = 4'b0000;
        checks++; if (IRQ_bar !== 1'b0) begin failures++; $display("[TB] FAIL prio_irq_lag got=%b exp=%b", IRQ_bar, 1'b0); end
        tick();
        checks++; if ({IRQ_bar, Any_irq, Vector_id} !== 4'b1000) begin failures++; $display("[TB] FAIL prio_idle got=%b exp=%b", {IRQ_bar, Any_irq, Vector_id}, 4'b1000); end
    endtask

    // Ack[1] on the same edge as a new Src[1] rise: the set wins.
    task automatic test_set_dominates();
        Src = 4'b1100; tick();
        Src = 4'b1110; tick();
        tick();
        checks++; if (FIRQ_bar !== 1'b0) begin failures++; $display("[TB] FAIL setdom_pre got=%b exp=%b", FIRQ_bar, 1'b0); end
        Src = 4'b1100; tick();
        Src = 4'b1110; Ack = 4'b0010; tick(); Ack = 4'b0000;
        checks++; if (Pending !== 4'b0010) begin failures++; $display("[TB] FAIL setdom_pending got=%b exp=%b", Pending, 4'b0010); end
        tick();
        checks++; if (FIRQ_bar !== 1'b0) begin failures++; $display("[TB] FAIL setdom_line got=%b exp=%b", FIRQ_bar, 1'b0); end
        Ack = 4'b0010; tick(); Ack = 4'b0000;
        tick();
        checks++; if ({Pending, FIRQ_bar} !== 5'b00001) begin failures++; $display("[TB] FAIL setdom_clear got=%b exp=%b", {Pending, FIRQ_bar}, 5'b00001); end
    endtask

    // Masked source still latches; unmasking raises its line a cycle later.
    task automatic test_mask();
        Mask_we = 1'b1; Mask_din = 4'b1011; tick(); Mask_we = 1'b0;
        checks++; if (Mask !== 4'b1011) begin failures++; $display("[TB] FAIL mask_load got=%b exp=%b", Mask, 4'b1011); end
        Src = 4'b1010; tick();
        Src = 4'b1110; tick();
        tick(); tick();
        checks++; if (Pending !== 4'b0100) begin failures++; $display("[TB] FAIL mask_pending got=%b exp=%b", Pending, 4'b0100); end
        checks++; if ({IRQ_bar, Any_irq} !== 2'b10) begin failures++; $display("[TB] FAIL mask_gated got=%b exp=%b", {IRQ_bar, Any_irq}, 2'b10); end
        Mask_we = 1'b1; Mask_din = 4'b1111; tick(); Mask_we = 1'b0;
        checks++; if (IRQ_bar !== 1'b1) begin failures++; $display("[TB] FAIL mask_lag got=%b exp=%b", IRQ_bar, 1'b1); end
        tick();
        checks++; if ({IRQ_bar, Vector_id} !== 3'b010) begin failures++; $display("[TB] FAIL mask_unmask got=%b exp=%b", {IRQ_bar, Vector_id}, 3'b010); end
        Ack = 4'b0100; tick(); Ack = 4'b0000;
        tick();
    endtask

    // Single NMI edge: exactly 8 low cycles, then auto-clear and high.
    task automatic test_nmi_single();
        int low_bad;
        Src = 4'b1111; tick();
        checks++; if ({Pending[0], NMI_bar} !== 2'b11) begin failures++; $display("[TB] FAIL nmi1_latch got=%b exp=%b", {Pending[0], NMI_bar}, 2'b11); end
        low_bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (NMI_bar !== 1'b0) low_bad++;
        end
        checks++; if (low_bad != 0) begin failures++; $display("[TB] FAIL nmi1_width high_cycles=%0d exp=%0d", low_bad, 0); end
        tick();
        checks++; if ({NMI_bar, Pending[0]} !== 2'b10) begin failures++; $display("[TB] FAIL nmi1_end got=%b exp=%b", {NMI_bar, Pending[0]}, 2'b10); end
        tick(); tick();
        checks++; if (NMI_bar !== 1'b1) begin failures++; $display("[TB] FAIL nmi1_idle got=%b exp=%b", NMI_bar, 1'b1); end
        Src = 4'b1110; tick();
    endtask

    // Second edge in the final pulse cycle: 1-cycle gap and a full second
    // pulse; Ack[0] in the middle of it does not shorten it.
    task automatic test_back_to_back();
        int low_bad;
        Src = 4'b1111; tick();
        Src = 4'b1110;
        low_bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (NMI_bar !== 1'b0) low_bad++;
        end
        checks++; if (low_bad != 0) begin failures++; $display("[TB] FAIL b2b_first high_cycles=%0d exp=%0d", low_bad, 0); end
        Src = 4'b1111; tick();
        checks++; if ({NMI_bar, Pending[0]} !== 2'b11) begin failures++; $display("[TB] FAIL b2b_gap got=%b exp=%b", {NMI_bar, Pending[0]}, 2'b11); end
        low_bad = 0;
        for (int i = 0; i < 8; i++) begin
            Ack = (i == 3) ? 4'b0001 : 4'b0000;
            tick();
            if (NMI_bar !== 1'b0) low_bad++;
        end
        Ack = 4'b0000;
        checks++; if (low_bad != 0) begin failures++; $display("[TB] FAIL b2b_second high_cycles=%0d exp=%0d", low_bad, 0); end
        checks++; if (Pending[0] !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ack0 got=%b exp=%b", Pending[0], 1'b0); end
        tick();
        checks++; if (NMI_bar !== 1'b1) begin failures++; $display("[TB] FAIL b2b_end got=%b exp=%b", NMI_bar, 1'b1); end
        Src = 4'b1110; tick(); tick();
    endtask

    // Reset during the fourth low cycle of a pulse.
    task automatic test_reset_mid_pulse();
        Mask_we = 1'b1; Mask_din = 4'b0111; tick(); Mask_we = 1'b0;
        Src = 4'b1111; tick();
        tick(); tick(); tick(); tick();
        checks++; if (NMI_bar !== 1'b0) begin failures++; $display("[TB] FAIL rstp_low got=%b exp=%b", NMI_bar, 1'b0); end
        Reset = 1'b1; tick();
        checks++; if ({NMI_bar, Pending, Mask} !== 9'b1_0000_1111) begin failures++; $display("[TB] FAIL rstp_state got=%b exp=%b", {NMI_bar, Pending, Mask}, 9'b1_0000_1111); end
        Reset = 1'b0; tick(); tick();
        checks++; if ({NMI_bar, Pending} !== 5'b1_0000) begin failures++; $display("[TB] FAIL rstp_after got=%b exp=%b", {NMI_bar, Pending}, 5'b1_0000); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_firq_edge();
        test_priority();
        test_set_dominates();
        test_mask();
        test_nmi_single();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
